// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker: seeds from the generator's state word, locks after
// LOCK_COUNT matches, then flywheels and counts mismatches. Option: LFSR_CHK_ZERO_DETECT_EN.
module lfsr_checker #(
   parameter int unsigned      WIDTH       = 8,
   parameter logic [WIDTH-1:0] TAPS        = 8'hB8,
   parameter int unsigned      LOCK_COUNT  = 16,
   parameter int unsigned      UNLOCK_ERRS = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] din,
   input  logic             err_clr,
   output logic             locked,
   output logic             error,
   output logic [15:0]      err_count,
   output logic [WIDTH-1:0] expect_word
`ifdef LFSR_CHK_ZERO_DETECT_EN
   ,
   output logic             stuck
`endif
);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_e;

   localparam logic [7:0]  LOCK_LIMIT   = 8'(LOCK_COUNT);
   localparam logic [3:0]  UNLOCK_LIMIT = 4'(UNLOCK_ERRS);
   localparam logic [15:0] COUNT_MAX    = 16'hFFFF;

   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
      return {x[WIDTH-2:0], ^(x & TAPS)};
   endfunction

   state_e           state_q, state_d;
   logic [WIDTH-1:0] expect_q, expect_d;
   logic [7:0]       match_cnt_q, match_cnt_d;
   logic [3:0]       miss_cnt_q, miss_cnt_d;
   logic             locked_q, locked_d;
   logic             error_q, error_d;
   logic [15:0]      err_count_q, err_count_d;
   logic             count_inc;
   logic             hit;

   assign hit = (din == expect_q);

`ifdef LFSR_CHK_ZERO_DETECT_EN
   logic stuck_q, stuck_d;
   logic din_zero;

   assign din_zero = (din == '0);
`endif

   always_comb begin
      // NOTE: every variable gets a hold/default value first so no path leaves it unassigned (no latches).
      state_d     = state_q;
      expect_d    = expect_q;
      match_cnt_d = match_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      locked_d    = locked_q;
      error_d     = 1'b0;
      err_count_d = err_count_q;
      count_inc   = 1'b0;
`ifdef LFSR_CHK_ZERO_DETECT_EN
      stuck_d     = 1'b0;
`endif

      if (enable) begin
         unique case (state_q)
            HUNT: begin
               expect_d    = step(din);
               match_cnt_d = 8'd0;
               state_d     = VERIFY;
`ifdef LFSR_CHK_ZERO_DETECT_EN
               if (din_zero) begin
                  expect_d = expect_q;
                  state_d  = HUNT;
               end
`endif
            end

            VERIFY: begin
               // A mismatch here simply reseeds; nothing is reported before lock.
               expect_d = step(din);
               if (hit) begin
                  match_cnt_d = match_cnt_q + 8'd1;
                  if (match_cnt_q + 8'd1 == LOCK_LIMIT) begin
                     state_d    = LOCKED;
                     locked_d   = 1'b1;
                     miss_cnt_d = 4'd0;
                  end
               end else begin
                  match_cnt_d = 8'd0;
               end
`ifdef LFSR_CHK_ZERO_DETECT_EN
               if (din_zero) begin
                  expect_d    = expect_q;
                  match_cnt_d = 8'd0;
                  state_d     = HUNT;
                  locked_d    = 1'b0;
               end
`endif
            end

            LOCKED: begin
               if (hit
`ifdef LFSR_CHK_ZERO_DETECT_EN
                   && !din_zero
`endif
               ) begin
                  expect_d   = step(din);
                  miss_cnt_d = 4'd0;
               end else begin
                  // Flywheel on the prediction; corrupted data must never reseed.
                  expect_d   = step(expect_q);
                  error_d    = 1'b1;
                  count_inc  = 1'b1;
                  miss_cnt_d = miss_cnt_q + 4'd1;
                  if (miss_cnt_q + 4'd1 == UNLOCK_LIMIT) begin
                     state_d     = HUNT;
                     locked_d    = 1'b0;
                     miss_cnt_d  = 4'd0;
                     match_cnt_d = 8'd0;
                  end
`ifdef LFSR_CHK_ZERO_DETECT_EN
                  if (din_zero) begin
                     state_d     = HUNT;
                     locked_d    = 1'b0;
                     miss_cnt_d  = 4'd0;
                     match_cnt_d = 8'd0;
                  end
`endif
               end
            end

            default: begin
               state_d  = HUNT;
               locked_d = 1'b0;
            end
         endcase

`ifdef LFSR_CHK_ZERO_DETECT_EN
         stuck_d = din_zero;
`endif

         // A clear coinciding with a new mismatch leaves exactly that one counted.
         if (err_clr) begin
            err_count_d = count_inc ? 16'd1 : 16'd0;
         end else if (count_inc && err_count_q != COUNT_MAX) begin
            err_count_d = err_count_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= HUNT;
         expect_q    <= '0;
         match_cnt_q <= 8'd0;
         miss_cnt_q  <= 4'd0;
         locked_q    <= 1'b0;
         error_q     <= 1'b0;
         err_count_q <= 16'd0;
`ifdef LFSR_CHK_ZERO_DETECT_EN
         stuck_q     <= 1'b0;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all flops update together.
         state_q     <= state_d;
         expect_q    <= expect_d;
         match_cnt_q <= match_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         locked_q    <= locked_d;
         error_q     <= error_d;
         err_count_q <= err_count_d;
`ifdef LFSR_CHK_ZERO_DETECT_EN
         stuck_q     <= stuck_d;
`endif
      end
   end

   assign locked      = locked_q;
   assign error       = error_q;
   assign err_count   = err_count_q;
   assign expect_word = expect_q;
`ifdef LFSR_CHK_ZERO_DETECT_EN
   assign stuck       = stuck_q;
`endif

endmodule
